data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LATENCY, default 4, meaning: total cycles BUSYWAIT is high per access; legal range 2..15.
REQ-002 Port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 Port RESET  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 Port READ  input  1  read request from control unit.
REQ-005 Port WRITE  input  1  write request from control unit.
REQ-006 Port ADDRESS  input  8  byte address (ALU result).
REQ-007 Port WRITEDATA  input  8  store data (register file OUT1).
REQ-008 Port READDATA  output  8  load data; feeds write-back select mux input.
REQ-009 Port BUSYWAIT  output  1  stall to PC and register file while access is in progress.

Function
REQ-010 Storage SHALL be 256 x 8-bit, indexed by ADDRESS.
REQ-011 FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-012 Valid request: exactly one of READ/WRITE high. Invalid: both high or both low.
REQ-013 IDLE with valid request: BUSYWAIT SHALL go high combinationally in the same cycle.
REQ-014 IDLE with valid request: next edge latches ADDRESS, WRITEDATA and op, loads counter with LATENCY-1, moves to ACCESS.
REQ-015 IDLE with both READ and WRITE high: no access starts, BUSYWAIT stays 0, state stays IDLE.
REQ-016 ACCESS: BUSYWAIT SHALL be 1; counter decrements each edge; at the edge where counter equals 1, moves to DONE.
REQ-017 ACCESS: changes on READ, WRITE, ADDRESS, WRITEDATA SHALL be ignored; latched values are used.
REQ-018 Transition ACCESS->DONE on a read: READDATA SHALL load mem[latched address] at that edge.
REQ-019 Transition ACCESS->DONE on a write: mem[latched address] SHALL load latched data at that edge.
REQ-020 Write: READDATA SHALL hold its previous value.
REQ-021 DONE: BUSYWAIT SHALL be 0 for exactly one cycle, so the CPU commits (PC advance / register write of READDATA) on the next edge.
REQ-022 DONE SHALL return to IDLE on the next edge unconditionally; a request still present at that edge is not re-sampled.
REQ-023 Consequence of REQ-013..REQ-022: BUSYWAIT is high for exactly LATENCY cycles per access.
REQ-024 READDATA SHALL be registered and stable from the DONE edge until the next completed read.
REQ-025 ADDRESS 8'hFF followed by 8'h00 SHALL address distinct locations; there is no address wrap logic.

Reset
REQ-026 Asserting RESET at any time SHALL immediately force: state IDLE, counter 0, READDATA 8'h00, BUSYWAIT 0 (once READ/WRITE are low), all 256 locations 8'h00.
REQ-027 RESET during ACCESS SHALL abort the access; a pending write SHALL NOT be committed.
REQ-028 After RESET deasserts, the first rising edge with a valid request SHALL start a new access per REQ-014.

Verification
REQ-029 Write then read, LATENCY=4: WRITE=1, ADDRESS=8'h10, WRITEDATA=8'hA5 -> BUSYWAIT high 4 cycles; then READ=1, ADDRESS=8'h10 -> BUSYWAIT high 4 cycles, READDATA=8'hA5 in DONE.
REQ-030 Mid-access input change: during ACCESS change ADDRESS to 8'h20 and WRITEDATA to 8'h3C -> mem[8'h10] receives the latched data, mem[8'h20] stays 8'h00.
REQ-031 Both-high request: READ=1, WRITE=1 -> BUSYWAIT stays 0, no memory location changes, READDATA unchanged.
REQ-032 Reset mid-write: issue write of 8'h77 to 8'h05, assert RESET in the 2nd ACCESS cycle -> BUSYWAIT 0 immediately, READDATA 8'h00; a later read of 8'h05 returns 8'h00.
REQ-033 Boundary addresses and back-to-back access: write 8'h11 to 8'hFF and 8'h22 to 8'h00 back to back -> read 8'hFF returns 8'h11, read 8'h00 returns 8'h22; exactly one DONE cycle between consecutive accesses.
REQ-034 LATENCY=2 build: repeat REQ-029 -> BUSYWAIT high exactly 2 cycles per access.

Source files
------------

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Purpose  : 256 x 8-bit data memory for a multi-cycle CPU. Each access keeps
//            BUSYWAIT high for LATENCY cycles and then spends one cycle in DONE
//            with BUSYWAIT low, so the CPU commits on the following edge.
//            ADDRESS, WRITEDATA and the operation are latched when the access
//            starts, so the CPU may change them while the access runs.
// Ports    : CLK       - system clock, rising edge
//            RESET     - asynchronous, active-high; clears state and memory
//            READ      - read request
//            WRITE     - write request
//            ADDRESS   - byte address [7:0]
//            WRITEDATA - store data [7:0]
//            READDATA  - registered load data [7:0]
//            BUSYWAIT  - stall while an access is in progress
// Revision : 1.0 - initial release
// ============================================================================
module data_memory #(
   parameter int LATENCY = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       READ,
   input  logic       WRITE,
   input  logic [7:0] ADDRESS,
   input  logic [7:0] WRITEDATA,
   output logic [7:0] READDATA,
   output logic       BUSYWAIT
);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_ACCESS = 2'd1;
   localparam logic [1:0] c_DONE   = 2'd2;

   // The IDLE cycle counts as the first busy cycle, so ACCESS lasts LATENCY-1.
   localparam logic [3:0] c_LOAD = 4'(LATENCY - 1);

   logic [1:0] r_state;
   logic [3:0] r_count;
   logic [7:0] r_addr;
   logic [7:0] r_data;
   logic       r_is_write;
   logic [7:0] r_mem [0:255];
   logic [7:0] r_readdata;

   logic w_valid;
   logic w_finish;

   // Exactly one of READ/WRITE forms a valid request.
   assign w_valid  = READ ^ WRITE;
   // Final ACCESS edge: the memory operation takes effect here.
   assign w_finish = (r_state == c_ACCESS) && (r_count == 4'd1);

   assign BUSYWAIT = (r_state == c_ACCESS) || ((r_state == c_IDLE) && w_valid);
   assign READDATA = r_readdata;

   // Control FSM, counter and request latch.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state    <= c_IDLE;
         r_count    <= 4'd0;
         r_addr     <= 8'h00;
         r_data     <= 8'h00;
         r_is_write <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_valid) begin
                  r_addr     <= ADDRESS;
                  r_data     <= WRITEDATA;
                  r_is_write <= WRITE;
                  r_count    <= c_LOAD;
                  r_state    <= c_ACCESS;
               end
            end
            c_ACCESS: begin
               r_count <= r_count - 4'd1;
               if (r_count == 4'd1) begin
                  r_state <= c_DONE;
               end
            end
            c_DONE: begin
               // Requests still held here are deliberately not re-sampled.
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Load data register; holds its value across writes.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_readdata <= 8'h00;
      end else if (w_finish && !r_is_write) begin
         r_readdata <= r_mem[r_addr];
      end
   end

   // Storage array; reset clears every location, aborting any pending write.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 256; i++) begin
            r_mem[i] <= 8'h00;
         end
      end else if (w_finish && r_is_write) begin
         r_mem[r_addr] <= r_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Purpose  : Directed testbench for data_memory. A LATENCY=4 and a LATENCY=2
//            instance share the request inputs; each scenario observes one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory;

   logic       clk;
   logic       rst;
   logic       rd;
   logic       wr;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata4;
   logic       busy4;
   logic [7:0] rdata2;
   logic       busy2;

   int n_total = 0;
   int n_bad   = 0;
   int nb;

   data_memory #(.LATENCY(4)) u_dut4 (
      .CLK       (clk),
      .RESET     (rst),
      .READ      (rd),
      .WRITE     (wr),
      .ADDRESS   (addr),
      .WRITEDATA (wdata),
      .READDATA  (rdata4),
      .BUSYWAIT  (busy4)
   );

   data_memory #(.LATENCY(2)) u_dut2 (
      .CLK       (clk),
      .RESET     (rst),
      .READ      (rd),
      .WRITE     (wr),
      .ADDRESS   (addr),
      .WRITEDATA (wdata),
      .READDATA  (rdata2),
      .BUSYWAIT  (busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Issues one request starting in the cycle after the next rising edge,
   // drops it once latched and counts busy cycles on falling edges. Returns
   // at the falling edge of the first non-busy cycle (DONE for a real access).
   task automatic run_access(input logic sel2, input logic r, input logic w,
                             input logic [7:0] a, input logic [7:0] d,
                             input logic mid_change, output int busy_cnt);
      busy_cnt = 0;
      @(posedge clk); #1;
      rd = r; wr = w; addr = a; wdata = d;
      @(negedge clk);
      if (sel2 ? busy2 : busy4) busy_cnt++;
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
      if (mid_change) begin
         addr  = 8'h20;
         wdata = 8'h3C;
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sel2 ? busy2 : busy4) busy_cnt++;
         else break;
      end
   endtask

   initial begin
      rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 8'h00; wdata = 8'h00;
      #12;
      chk("reset_busy", 32'(busy4), 32'd0);
      chk("reset_rdata", 32'(rdata4), 32'h00);
      @(posedge clk); #1;
      rst = 1'b0;

      // Write then read back, LATENCY=4
      run_access(1'b0, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, nb);
      chk("wr10_busy", 32'(nb), 32'd4);
      chk("wr10_rdata_hold", 32'(rdata4), 32'h00);
      run_access(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, nb);
      chk("rd10_busy", 32'(nb), 32'd4);
      chk("rd10_data", 32'(rdata4), 32'hA5);

      // Inputs change during ACCESS; latched address/data must be used
      run_access(1'b0, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b1, nb);
      chk("wrmid_busy", 32'(nb), 32'd4);
      chk("wrmid_rdata_hold", 32'(rdata4), 32'hA5);
      run_access(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, nb);
      chk("rd20_data", 32'(rdata4), 32'h00);
      run_access(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, nb);
      chk("rd10_latched", 32'(rdata4), 32'h5A);

      // Both READ and WRITE high: nothing happens
      run_access(1'b0, 1'b1, 1'b1, 8'h30, 8'hEE, 1'b0, nb);
      chk("both_busy", 32'(nb), 32'd0);
      chk("both_rdata", 32'(rdata4), 32'h5A);
      run_access(1'b0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, nb);
      chk("rd30_data", 32'(rdata4), 32'h00);
      run_access(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, nb);
      chk("rd10_again", 32'(rdata4), 32'h5A);

      // Reset during the 2nd ACCESS cycle of a write
      @(posedge clk); #1;
      wr = 1'b1; addr = 8'h05; wdata = 8'h77;
      @(posedge clk); #1;
      wr = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rstmid_busy", 32'(busy4), 32'd0);
      chk("rstmid_rdata", 32'(rdata4), 32'h00);
      @(posedge clk); #1;
      rst = 1'b0;
      run_access(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, nb);
      chk("rd05_busy", 32'(nb), 32'd4);
      chk("rd05_data", 32'(rdata4), 32'h00);
      run_access(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, nb);
      chk("rd10_cleared", 32'(rdata4), 32'h00);

      // Boundary addresses, back to back (one DONE cycle between accesses)
      run_access(1'b0, 1'b0, 1'b1, 8'hFF, 8'h11, 1'b0, nb);
      chk("wrFF_busy", 32'(nb), 32'd4);
      chk("wrFF_done", 32'(busy4), 32'd0);
      run_access(1'b0, 1'b0, 1'b1, 8'h00, 8'h22, 1'b0, nb);
      chk("wr00_busy", 32'(nb), 32'd4);
      run_access(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, nb);
      chk("rdFF_data", 32'(rdata4), 32'h11);
      run_access(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, nb);
      chk("rd00_data", 32'(rdata4), 32'h22);

      // LATENCY=2 instance: write then read
      run_access(1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, nb);
      chk("l2_wr_busy", 32'(nb), 32'd2);
      run_access(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, nb);
      chk("l2_rd_busy", 32'(nb), 32'd2);
      chk("l2_rd_data", 32'(rdata2), 32'hA5);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
